// File: rtl/pcap_dma_pkg.sv
// Shared types and defaults for the pcap capture-to-DMA buffer.
package pcap_dma_pkg;

  localparam int DEFAULT_DEPTH       = 1024;
  localparam int DEFAULT_FULL_MARGIN = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pcap_fifo.sv
// Synchronous show-ahead FIFO on an inferred RAM with a registered head word.
module pcap_fifo #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_data,
  input  logic                   i_pop,
  output logic [DW-1:0]          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_head;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = i_pop && (r_count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = i_push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + AW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // Bypass when the word being written is the one that becomes the head.
      r_head   <= (w_push && (r_wr_ptr == w_rd_next)) ? i_data : r_mem[w_rd_next];
    end
  end

  assign o_head  = (r_count != '0) ? r_head : '0;
  assign o_count = r_count;
  assign o_drop  = i_push && !w_push;

endmodule

// File: rtl/pcap_dma_buffer.sv
// Buffers pcap capture words and hands them to a DMA engine in request/ack bursts.
module pcap_dma_buffer
  import pcap_dma_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int FULL_MARGIN = DEFAULT_FULL_MARGIN
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [31:0]            pcap_dat_i,
  input  logic                   pcap_dat_valid_i,
  input  logic                   pcap_actv_i,
  input  logic                   pcap_done_i,
  input  logic [7:0]             BURST_LEN,
  output logic                   dma_req_o,
  output logic [8:0]             dma_len_o,
  input  logic                   dma_ack_i,
  output logic [31:0]            dma_dat_o,
  input  logic                   dma_rd_i,
  output logic                   dma_full_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] fill_level_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t      r_state;
  logic [8:0]  r_len;
  logic [8:0]  r_cnt;
  logic        r_actv_d;
  logic        r_rearm_pend;
  logic        r_flush_pend;
  logic        r_overflow;
  logic        r_done;

  logic [LW-1:0] w_fill;
  logic          w_drop;
  logic [8:0]    w_blen;
  logic [8:0]    w_take;
  logic          w_pop;
  logic          w_pop_eff;
  logic          w_actv_rise;
  logic          w_rearm;
  logic          w_done_in;
  logic          w_done_fire;
  logic          w_start;

  assign w_blen      = (BURST_LEN == 8'd0) ? 9'd1 : {1'b0, BURST_LEN};
  assign w_take      = 9'(imin(int'(w_fill), int'(w_blen)));
  assign w_pop       = dma_rd_i && (r_state == ST_XFER);
  assign w_pop_eff   = w_pop && (w_fill != '0);
  assign w_actv_rise = pcap_actv_i && !r_actv_d;
  // A re-arm only takes effect in IDLE; edges seen mid-burst wait in r_rearm_pend.
  assign w_rearm     = (r_state == ST_IDLE) && (w_actv_rise || r_rearm_pend);
  assign w_done_in   = pcap_done_i && !w_actv_rise && !w_rearm;
  assign w_done_fire = (r_state == ST_IDLE) && r_flush_pend && (w_fill == '0) && !w_rearm;
  assign w_start     = !w_rearm && ((int'(w_fill) >= int'(w_blen)) ||
                                    (r_flush_pend && (w_fill != '0)));

  pcap_fifo #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_clear (w_rearm),
    .i_push  (pcap_dat_valid_i),
    .i_data  (pcap_dat_i),
    .i_pop   (w_pop),
    .o_head  (dma_dat_o),
    .o_count (w_fill),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_actv_d     <= 1'b0;
      r_rearm_pend <= 1'b0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_actv_d <= pcap_actv_i;
      r_done   <= w_done_fire;

      if (w_rearm)          r_rearm_pend <= 1'b0;
      else if (w_actv_rise) r_rearm_pend <= 1'b1;

      if (w_rearm)     r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      // A new end-of-capture wins over the completion of an older flush.
      if (w_rearm)          r_flush_pend <= 1'b0;
      else if (w_done_in)   r_flush_pend <= 1'b1;
      else if (w_done_fire) r_flush_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_REQ;
            r_len   <= w_take;
          end
        end
        ST_REQ: begin
          if (dma_ack_i) begin
            r_state <= ST_XFER;
            r_cnt   <= '0;
          end
        end
        ST_XFER: begin
          if (w_pop_eff) begin
            r_cnt <= r_cnt + 9'd1;
            if (r_cnt + 9'd1 == r_len) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_req_o    = (r_state == ST_REQ);
  assign dma_len_o    = r_len;
  assign dma_full_o   = int'(w_fill) >= (DEPTH - FULL_MARGIN);
  assign done_o       = r_done;
  assign overflow_o   = r_overflow;
  assign fill_level_o = w_fill;

endmodule

// File: tb/tb_pcap_dma_buffer.sv
// Directed and randomized bench for pcap_dma_buffer against a queue-based reference model.
module tb_pcap_dma_buffer;

  localparam int DEPTH       = 1024;
  localparam int FULL_MARGIN = 16;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [31:0]   pcap_dat_i;
  logic          pcap_dat_valid_i;
  logic          pcap_actv_i;
  logic          pcap_done_i;
  logic [7:0]    BURST_LEN;
  logic          dma_req_o;
  logic [8:0]    dma_len_o;
  logic          dma_ack_i;
  logic [31:0]   dma_dat_o;
  logic          dma_rd_i;
  logic          dma_full_o;
  logic          done_o;
  logic          overflow_o;
  logic [LW-1:0] fill_level_o;

  always #5 clk_i = ~clk_i;

  pcap_dma_buffer #(
    .DEPTH       (DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pcap_dat_i       (pcap_dat_i),
    .pcap_dat_valid_i (pcap_dat_valid_i),
    .pcap_actv_i      (pcap_actv_i),
    .pcap_done_i      (pcap_done_i),
    .BURST_LEN        (BURST_LEN),
    .dma_req_o        (dma_req_o),
    .dma_len_o        (dma_len_o),
    .dma_ack_i        (dma_ack_i),
    .dma_dat_o        (dma_dat_o),
    .dma_rd_i         (dma_rd_i),
    .dma_full_o       (dma_full_o),
    .done_o           (done_o),
    .overflow_o       (overflow_o),
    .fill_level_o     (fill_level_o)
  );

  int          tests    = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  int          blen_eff = 1;
  bit          model_ovf = 1'b0;
  logic [31:0] q[$];

  always @(negedge clk_i) begin
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_blen(input int b);
    BURST_LEN = 8'(b);
    blen_eff  = (b == 0) ? 1 : b;
  endtask

  task automatic push_word(input logic [31:0] d);
    pcap_dat_i       = d;
    pcap_dat_valid_i = 1'b1;
    cyc();
    pcap_dat_valid_i = 1'b0;
    if (q.size() < DEPTH) q.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (dma_req_o !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk("req_seen", 32'(dma_req_o), 32'd1);
  endtask

  task automatic pop_word(input int idle);
    logic [31:0] exp_head;
    repeat (idle) cyc();
    exp_head = q[0];
    chk("head", dma_dat_o, exp_head);
    dma_rd_i = 1'b1;
    cyc();
    dma_rd_i = 1'b0;
    void'(q.pop_front());
    chk("fill_after_pop", 32'(fill_level_o), 32'(q.size()));
  endtask

  task automatic do_burst(input int exp_len, input bit gaps);
    wait_req();
    chk("len", 32'(dma_len_o), 32'(exp_len));
    dma_ack_i = 1'b1;
    cyc();
    dma_ack_i = 1'b0;
    chk("req_low_after_ack", 32'(dma_req_o), 32'd0);
    for (int i = 0; i < exp_len; i++) pop_word(gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},  32'(dma_req_o),    32'd0);
    chk({tag, "_len"},  32'(dma_len_o),    32'd0);
    chk({tag, "_full"}, 32'(dma_full_o),   32'd0);
    chk({tag, "_done"}, 32'(done_o),       32'd0);
    chk({tag, "_ovf"},  32'(overflow_o),   32'd0);
    chk({tag, "_fill"}, 32'(fill_level_o), 32'd0);
    chk({tag, "_dat"},  dma_dat_o,         32'd0);
  endtask

  initial begin
    int d0;
    int w;
    reset_i          = 1'b1;
    pcap_dat_i       = '0;
    pcap_dat_valid_i = 1'b0;
    pcap_actv_i      = 1'b0;
    pcap_done_i      = 1'b0;
    BURST_LEN        = 8'd4;
    dma_ack_i        = 1'b0;
    dma_rd_i         = 1'b0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    reset_i = 1'b0;
    cyc();

    // Full burst of four known words; a read while in REQ must be ignored.
    set_blen(4);
    for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
    chk("fill_4", 32'(fill_level_o), 32'd4);
    wait_req();
    dma_rd_i = 1'b1;
    cyc();
    dma_rd_i = 1'b0;
    chk("rd_in_req_ignored", 32'(fill_level_o), 32'd4);
    chk("head_first", dma_dat_o, 32'h10);
    do_burst(4, 1'b0);
    cyc();
    chk("idle_after_burst_req", 32'(dma_req_o), 32'd0);
    chk("idle_after_burst_fill", 32'(fill_level_o), 32'd0);

    // Randomized bursts with varying lengths (0 behaves as 1) and read gaps.
    for (int it = 0; it < 8; it++) begin
      set_blen(int'($urandom_range(0, 8)));
      w = int'($urandom_range(0, 12));
      for (int j = 0; j < w; j++) push_word($urandom());
      while (q.size() >= blen_eff) do_burst(blen_eff, 1'b1);
    end
    d0 = done_cnt;
    pcap_done_i = 1'b1;
    cyc();
    pcap_done_i = 1'b0;
    while (q.size() > 0) do_burst((q.size() < blen_eff) ? q.size() : blen_eff, 1'b1);
    repeat (4) cyc();
    chk("rand_flush_done_once", 32'(done_cnt - d0), 32'd1);
    chk("rand_flush_fill", 32'(fill_level_o), 32'd0);

    // Partial flush: three words against a burst length of eight.
    set_blen(8);
    for (int i = 0; i < 3; i++) push_word($urandom());
    cyc();
    chk("partial_no_req", 32'(dma_req_o), 32'd0);
    d0 = done_cnt;
    pcap_done_i = 1'b1;
    cyc();
    pcap_done_i = 1'b0;
    do_burst(3, 1'b0);
    repeat (5) cyc();
    chk("partial_done_once", 32'(done_cnt - d0), 32'd1);

    // Overflow: 1030 writes with nobody draining.
    set_blen(255);
    for (int i = 0; i < 1030; i++) begin
      push_word($urandom());
      chk("full_flag", 32'(dma_full_o), 32'(q.size() >= DEPTH - FULL_MARGIN));
    end
    chk("ovf_fill", 32'(fill_level_o), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow_o), 32'(model_ovf));

    // Re-arm during XFER is deferred until the burst completes.
    wait_req();
    chk("ovf_len", 32'(dma_len_o), 32'd255);
    dma_ack_i = 1'b1;
    cyc();
    dma_ack_i = 1'b0;
    pop_word(0);
    pcap_actv_i = 1'b1;
    cyc();
    pcap_actv_i = 1'b0;
    chk("rearm_deferred_fill", 32'(fill_level_o), 32'd1023);
    chk("rearm_deferred_ovf", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 254; i++) pop_word(0);
    cyc();
    q.delete();
    model_ovf = 1'b0;
    chk("rearm_fill", 32'(fill_level_o), 32'd0);
    chk("rearm_ovf", 32'(overflow_o), 32'(model_ovf));
    chk("rearm_full", 32'(dma_full_o), 32'd0);
    cyc();
    chk("rearm_no_req", 32'(dma_req_o), 32'd0);

    // Re-arm in IDLE coinciding with pcap_done: FIFO empties, done is discarded.
    set_blen(8);
    push_word($urandom());
    push_word($urandom());
    chk("pre_rearm_fill", 32'(fill_level_o), 32'(q.size()));
    d0 = done_cnt;
    pcap_actv_i = 1'b1;
    pcap_done_i = 1'b1;
    cyc();
    pcap_actv_i = 1'b0;
    pcap_done_i = 1'b0;
    q.delete();
    chk("rearm_idle_fill", 32'(fill_level_o), 32'd0);
    repeat (5) cyc();
    chk("rearm_done_discarded", 32'(done_cnt - d0), 32'd0);
    chk("rearm_idle_no_req", 32'(dma_req_o), 32'd0);

    // Reset in the middle of a burst with a flush pending.
    set_blen(4);
    for (int i = 0; i < 4; i++) push_word($urandom());
    wait_req();
    dma_ack_i = 1'b1;
    cyc();
    dma_ack_i = 1'b0;
    pop_word(0);
    pop_word(0);
    pcap_done_i = 1'b1;
    cyc();
    pcap_done_i = 1'b0;
    d0 = done_cnt;
    reset_i = 1'b1;
    cyc();
    chk_reset_outputs("midxfer");
    reset_i = 1'b0;
    q.delete();
    repeat (10) cyc();
    chk("midxfer_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midxfer_fill", 32'(fill_level_o), 32'd0);
    chk("midxfer_req", 32'(dma_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
